// File: rtl/bcd_pkg.sv
// Shared constants for the N-digit BCD counter: digit limits and the active-low
// 7-segment pattern table (bit 0 = segment a, bit 6 = segment g).
package bcd_pkg;

    localparam int         DIGIT_W = 4;
    localparam logic [3:0] BCD_MAX = 4'd9;
    localparam logic [3:0] BCD_MIN = 4'd0;

    localparam logic [6:0] SEG7_BLANK = 7'b1111111;

    // Active-low patterns, ordered {g,f,e,d,c,b,a}.
    localparam logic [6:0] SEG7_TABLE [10] = '{
        7'b1000000,  // 0
        7'b1111001,  // 1
        7'b0100100,  // 2
        7'b0110000,  // 3
        7'b0011001,  // 4
        7'b0010010,  // 5
        7'b0000010,  // 6
        7'b1111000,  // 7
        7'b0000000,  // 8
        7'b0010000   // 9
    };

    function automatic logic [6:0] seg7_pattern(input logic [3:0] digit);
        logic [6:0] pat;
        pat = SEG7_BLANK;
        if (digit <= BCD_MAX) begin
            pat = SEG7_TABLE[digit];
        end
        return pat;
    endfunction

    function automatic logic [3:0] bcd_sanitize(input logic [3:0] digit);
        return (digit > BCD_MAX) ? BCD_MIN : digit;
    endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// One BCD digit register. i_cin is the step request rippling in from the lower digit;
// o_cout requests a step from the next digit (carry when counting up, borrow when down).
module bcd_digit_cell
    import bcd_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_clr,
    input  logic               i_load,
    input  logic [DIGIT_W-1:0] i_load_digit,
    input  logic               i_up_dn,
    input  logic               i_cin,
    output logic [DIGIT_W-1:0] o_digit,
    output logic [DIGIT_W-1:0] o_digit_next,
    output logic               o_cout
);

    logic [DIGIT_W-1:0] r_digit;
    logic [DIGIT_W-1:0] w_next;
    logic               w_at_limit;

    assign w_at_limit = i_up_dn ? (r_digit == BCD_MAX) : (r_digit == BCD_MIN);

    always_comb begin
        w_next = r_digit;
        if (i_clr) begin
            w_next = BCD_MIN;
        end else if (i_load) begin
            w_next = bcd_sanitize(i_load_digit);
        end else if (i_cin) begin
            if (i_up_dn) begin
                w_next = w_at_limit ? BCD_MIN : r_digit + 4'd1;
            end else begin
                w_next = w_at_limit ? BCD_MAX : r_digit - 4'd1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_digit <= BCD_MIN;
        end else begin
            r_digit <= w_next;
        end
    end

    assign o_digit      = r_digit;
    assign o_digit_next = w_next;
    assign o_cout       = i_cin & w_at_limit;

endmodule

// File: rtl/bcd_counter_ndigit.sv
// N-digit BCD up/down counter stepping on a free-running prescaler tick.
// Define SEG7_OUT_EN to add the registered active-low 7-segment output HEX.
module bcd_counter_ndigit
    import bcd_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int TICK_DIV   = 50000000
) (
    input  logic                          CLOCK_50,
    input  logic                          KEY,
    input  logic                          en,
    input  logic                          up_dn,
    input  logic                          clr,
    input  logic                          load,
    input  logic [DIGIT_W*NUM_DIGITS-1:0] load_val,
    output logic [DIGIT_W*NUM_DIGITS-1:0] count,
    output logic                          wrap,
`ifdef SEG7_OUT_EN
    output logic [7*NUM_DIGITS-1:0]       HEX,
`endif
    output logic                          tick
);

    localparam int            PW         = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0]                   r_presc;
    logic                            r_tick;
    logic                            r_wrap;
    logic [NUM_DIGITS:0]             w_carry;
    logic [DIGIT_W*NUM_DIGITS-1:0]   w_count_next;

    // Prescaler runs regardless of en/clr/load so chained blocks stay phase-locked.
    always_ff @(posedge CLOCK_50 or negedge KEY) begin
        if (!KEY) begin
            r_presc <= '0;
            r_tick  <= 1'b0;
        end else begin
            r_presc <= (r_presc == PRESC_LAST) ? '0 : r_presc + PW'(1);
            r_tick  <= (r_presc == PRESC_LAST);
        end
    end

    assign w_carry[0] = r_tick & en;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            bcd_digit_cell u_cell (
                .i_clk        (CLOCK_50),
                .i_rst_n      (KEY),
                .i_clr        (clr),
                .i_load       (load),
                .i_load_digit (load_val[DIGIT_W*gi +: DIGIT_W]),
                .i_up_dn      (up_dn),
                .i_cin        (w_carry[gi]),
                .o_digit      (count[DIGIT_W*gi +: DIGIT_W]),
                .o_digit_next (w_count_next[DIGIT_W*gi +: DIGIT_W]),
                .o_cout       (w_carry[gi+1])
            );
        end
    endgenerate

    // Carry out of the top digit means every digit sat at its limit: wrap/borrow.
    always_ff @(posedge CLOCK_50 or negedge KEY) begin
        if (!KEY) begin
            r_wrap <= 1'b0;
        end else begin
            r_wrap <= w_carry[NUM_DIGITS] & ~clr & ~load;
        end
    end

    assign wrap = r_wrap;
    assign tick = r_tick;

`ifdef SEG7_OUT_EN
    logic [7*NUM_DIGITS-1:0] r_hex;

    always_ff @(posedge CLOCK_50 or negedge KEY) begin
        if (!KEY) begin
            r_hex <= {(7*NUM_DIGITS){1'b1}};
        end else begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                r_hex[7*i +: 7] <= seg7_pattern(w_count_next[DIGIT_W*i +: DIGIT_W]);
            end
        end
    end

    assign HEX = r_hex;
`else
    logic w_unused_next;
    assign w_unused_next = ^w_count_next;
`endif

endmodule

// File: tb/tb_bcd_counter_ndigit.sv
// Randomized bench for bcd_counter_ndigit against an integer-valued decimal model.
// Define SEG7_OUT_EN to also check HEX.
module tb_bcd_counter_ndigit;

    localparam int ND   = 2;
    localparam int TD   = 4;
    localparam int W    = 4 * ND;
    localparam int MAXV = 10 ** ND - 1;

    logic         CLOCK_50 = 1'b0;
    logic         KEY      = 1'b0;
    logic         en       = 1'b0;
    logic         up_dn    = 1'b1;
    logic         clr      = 1'b0;
    logic         load     = 1'b0;
    logic [W-1:0] load_val = '0;
    logic [W-1:0] count;
    logic         wrap;
    logic         tick;
`ifdef SEG7_OUT_EN
    logic [7*ND-1:0] HEX;
`endif

    bcd_counter_ndigit #(.NUM_DIGITS(ND), .TICK_DIV(TD)) dut (
        .CLOCK_50 (CLOCK_50),
        .KEY      (KEY),
        .en       (en),
        .up_dn    (up_dn),
        .clr      (clr),
        .load     (load),
        .load_val (load_val),
        .count    (count),
        .wrap     (wrap),
`ifdef SEG7_OUT_EN
        .HEX      (HEX),
`endif
        .tick     (tick)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int checks   = 0;
    int failures = 0;
    int nwrap    = 0;

    int m_cnt  = 0;
    int m_k    = 0;
    bit m_tick = 1'b0;
    bit m_wrap = 1'b0;

    function automatic logic [W-1:0] to_bcd(input int v);
        logic [W-1:0] r;
        int x;
        x = v;
        r = '0;
        for (int i = 0; i < ND; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic int from_load(input logic [W-1:0] lv);
        int s, p, d;
        s = 0;
        p = 1;
        for (int i = 0; i < ND; i++) begin
            d = int'(lv[4*i +: 4]);
            if (d > 9) d = 0;
            s = s + d * p;
            p = p * 10;
        end
        return s;
    endfunction

`ifdef SEG7_OUT_EN
    function automatic logic [7*ND-1:0] exp_hex(input int v);
        logic [6:0] segs [10];
        logic [7*ND-1:0] r;
        int x;
        segs = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
        x = v;
        for (int i = 0; i < ND; i++) begin
            r[7*i +: 7] = segs[x % 10];
            x = x / 10;
        end
        return r;
    endfunction
`endif

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Called at a negedge: drive, take one rising edge, update the model, check, return at next negedge.
    task automatic step(input logic e, input logic u, input logic c, input logic l,
                        input logic [W-1:0] lv);
        en = e; up_dn = u; clr = c; load = l; load_val = lv;
        @(posedge CLOCK_50);
        if (c) begin
            m_cnt = 0; m_wrap = 1'b0;
        end else if (l) begin
            m_cnt = from_load(lv); m_wrap = 1'b0;
        end else if (m_tick && e) begin
            if (u) begin
                m_wrap = (m_cnt == MAXV);
                m_cnt  = m_wrap ? 0 : m_cnt + 1;
            end else begin
                m_wrap = (m_cnt == 0);
                m_cnt  = m_wrap ? MAXV : m_cnt - 1;
            end
        end else begin
            m_wrap = 1'b0;
        end
        m_k++;
        m_tick = (m_k >= TD) && (m_k % TD == 0);
        #1;
        check("count", 32'(count), 32'(to_bcd(m_cnt)));
        check("wrap", 32'(wrap), 32'(m_wrap));
        check("tick", 32'(tick), 32'(m_tick));
`ifdef SEG7_OUT_EN
        check("hex", 32'(HEX), 32'(exp_hex(m_cnt)));
`endif
        if (wrap) nwrap++;
        @(negedge CLOCK_50);
    endtask

    task automatic idle_until_tick();
        for (int i = 0; i < TD && !m_tick; i++) step(1'b0, 1'b1, 1'b0, 1'b0, '0);
    endtask

    task automatic model_reset();
        m_cnt = 0; m_k = 0; m_tick = 1'b0; m_wrap = 1'b0;
    endtask

    initial begin
        KEY = 1'b0;
        #12;
        check("rst_count", 32'(count), 32'h0);
        check("rst_wrap", 32'(wrap), 32'h0);
        check("rst_tick", 32'(tick), 32'h0);
`ifdef SEG7_OUT_EN
        check("rst_hex", 32'(HEX), {(32-7*ND)'(0), {(7*ND){1'b1}}});
`endif
        @(negedge CLOCK_50);
        KEY = 1'b1;
        model_reset();

        // Count up from zero through 09 -> 10 with no wrap.
        nwrap = 0;
        for (int i = 0; i < 11 * TD; i++) step(1'b1, 1'b1, 1'b0, 1'b0, '0);
        check("up_to_10", 32'(count), 32'h10);
        check("up_no_wrap", 32'(nwrap), 32'd0);

        // 98 -> 99 -> 00 with a single wrap pulse.
        step(1'b0, 1'b1, 1'b0, 1'b1, 8'h98);
        nwrap = 0;
        for (int i = 0; i < 2 * TD; i++) step(1'b1, 1'b1, 1'b0, 1'b0, '0);
        check("up_wrap_cnt", 32'(count), 32'h00);
        check("up_wrap_pulses", 32'(nwrap), 32'd1);

        // 01 -> 00 -> 99 (borrow) -> 98.
        step(1'b0, 1'b0, 1'b0, 1'b1, 8'h01);
        nwrap = 0;
        for (int i = 0; i < 2 * TD; i++) step(1'b1, 1'b0, 1'b0, 1'b0, '0);
        check("dn_wrap_cnt", 32'(count), 32'h99);
        check("dn_wrap_pulses", 32'(nwrap), 32'd1);
        for (int i = 0; i < TD; i++) step(1'b1, 1'b0, 1'b0, 1'b0, '0);
        check("dn_98", 32'(count), 32'h98);
        check("dn_98_pulses", 32'(nwrap), 32'd1);

        // Invalid digit sanitised; load wins over a simultaneous tick.
        step(1'b0, 1'b1, 1'b0, 1'b1, 8'hA5);
        check("load_a5", 32'(count), 32'h05);
        idle_until_tick();
        step(1'b1, 1'b1, 1'b0, 1'b1, 8'h37);
        check("load_on_tick", 32'(count), 32'h37);

        // Asynchronous reset in the middle of a clock phase.
        step(1'b0, 1'b1, 1'b0, 1'b1, 8'h47);
        #2 KEY = 1'b0;
        #1;
        check("async_rst_cnt", 32'(count), 32'h0);
        check("async_rst_tick", 32'(tick), 32'h0);
        @(negedge CLOCK_50);
        KEY = 1'b1;
        model_reset();

        // Clear beats a wrapping tick.
        step(1'b0, 1'b1, 1'b0, 1'b1, 8'h99);
        idle_until_tick();
        step(1'b1, 1'b1, 1'b1, 1'b0, '0);
        check("clr_on_tick", 32'(count), 32'h00);
        check("clr_on_tick_wrap", 32'(wrap), 32'h0);

        for (int i = 0; i < 800; i++) begin
            step(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 40) == 0), ($urandom_range(0, 15) == 0),
                 W'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
